// File: rtl/mips_pkg.sv
// Shared MIPS-I encodings for the ALU: opcodes, funct codes, flag bit indices.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  // Loads occupy a contiguous range; stores are a sparse set
  localparam logic [5:0] OP_LOAD_LO = 6'b100000;
  localparam logic [5:0] OP_LOAD_HI = 6'b100110;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SWL     = 6'b101010;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_SWR     = 6'b101110;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Flag vector bit positions
  localparam int unsigned FLG_BR  = 0;
  localparam int unsigned FLG_NEG = 1;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_W   = 3;

  typedef enum logic [1:0] {
    SH_LEFT   = 2'd0,
    SH_LRIGHT = 2'd1,
    SH_ARIGHT = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left, logical right, arithmetic right.
module alu_shifter
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] value,
  input  logic [4:0]        amount,
  input  shift_mode_e       mode,
  output logic [WORD_W-1:0] shifted_c
);

  // Select the shift direction/fill; amount 0 passes value through
  always_comb begin
    shifted_c = value;
    case (mode)
      SH_LEFT:   shifted_c = value << amount;
      SH_LRIGHT: shifted_c = value >> amount;
      SH_ARIGHT: shifted_c = WORD_W'($signed(value) >>> amount);
      default:   shifted_c = value;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS-I integer ALU: decodes the instruction word, produces result and flags.
module mips_alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] result,
  output logic [FLG_W-1:0] flags
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_rs;

  logic [WIDTH-1:0] sum, diff, shifted;
  logic             add_ovf, sub_ovf, lt_s, lt_u;
  logic [4:0]       sh_amt;
  shift_mode_e      sh_mode;

  logic [WIDTH-1:0] result_d, result_q;
  logic [FLG_W-1:0] flags_d, flags_q;
  logic             br_d, ovf_d;

  assign opcode    = instruction[31:26];
  assign rt        = instruction[20:16];
  assign imm       = instruction[15:0];
  assign shamt     = instruction[10:6];
  assign funct     = instruction[5:0];
  assign unused_rs = ^instruction[25:21];

  // Shared arithmetic; overflow only when operand signs agree with each other but not the result
  assign sum     = reg_a + reg_b;
  assign diff    = reg_a - reg_b;
  assign add_ovf = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) && (sum[WIDTH-1] != reg_a[WIDTH-1]);
  assign sub_ovf = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (diff[WIDTH-1] != reg_a[WIDTH-1]);
  assign lt_s    = $signed(reg_a) < $signed(reg_b);
  assign lt_u    = reg_a < reg_b;

  // Variable shifts take their amount from rs, fixed shifts from shamt
  always_comb begin
    sh_amt  = shamt;
    sh_mode = SH_LEFT;
    if (funct == F_SLLV || funct == F_SRLV || funct == F_SRAV) sh_amt = reg_a[4:0];
    if (funct == F_SRL || funct == F_SRLV) sh_mode = SH_LRIGHT;
    if (funct == F_SRA || funct == F_SRAV) sh_mode = SH_ARIGHT;
  end

  alu_shifter u_shifter (
    .value     (reg_b),
    .amount    (sh_amt),
    .mode      (sh_mode),
    .shifted_c (shifted)
  );

  // Operation decode; anything unlisted yields zero result and flags
  always_comb begin
    result_d = '0;
    br_d     = 1'b0;
    ovf_d    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:  begin result_d = sum;  ovf_d = add_ovf; end
          F_ADDU: result_d = sum;
          F_SUB:  begin result_d = diff; ovf_d = sub_ovf; end
          F_SUBU: result_d = diff;
          F_AND:  result_d = reg_a & reg_b;
          F_OR:   result_d = reg_a | reg_b;
          F_XOR:  result_d = reg_a ^ reg_b;
          F_NOR:  result_d = ~(reg_a | reg_b);
          F_SLT:  result_d = WIDTH'(lt_s);
          F_SLTU: result_d = WIDTH'(lt_u);
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: result_d = shifted;
          F_JR:   result_d = '0;
          default: result_d = '0;
        endcase
      end
      OP_ADDI:  begin result_d = sum; ovf_d = add_ovf; end
      OP_ADDIU: result_d = sum;
      OP_SLTI:  result_d = WIDTH'(lt_s);
      OP_SLTIU: result_d = WIDTH'(lt_u);
      OP_ANDI:  result_d = reg_a & WIDTH'(imm);
      OP_ORI:   result_d = reg_a | WIDTH'(imm);
      OP_XORI:  result_d = reg_a ^ WIDTH'(imm);
      OP_LUI:   result_d = WIDTH'({imm, 16'h0000});
      OP_BEQ:   begin result_d = diff; br_d = (reg_a == reg_b); end
      OP_BNE:   begin result_d = diff; br_d = (reg_a != reg_b); end
      OP_BLEZ:  begin result_d = diff; br_d = reg_a[WIDTH-1] || (reg_a == '0); end
      OP_BGTZ:  begin result_d = diff; br_d = !reg_a[WIDTH-1] && (reg_a != '0); end
      OP_REGIMM: begin
        result_d = diff;
        if (rt == RT_BLTZ)      br_d = reg_a[WIDTH-1];
        else if (rt == RT_BGEZ) br_d = !reg_a[WIDTH-1];
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: result_d = sum;
      OP_J, OP_JAL: result_d = '0;
      default: begin
        if (opcode >= OP_LOAD_LO && opcode <= OP_LOAD_HI) result_d = sum;
      end
    endcase
    flags_d          = '0;
    flags_d[FLG_BR]  = br_d;
    flags_d[FLG_NEG] = result_d[WIDTH-1];
    flags_d[FLG_OVF] = ovf_d;
  end

  // Output register: synchronous active-low reset beats enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (enable) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: driver pushes expected values, monitor pops and compares.
module tb_mips_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] reg_a = '0;
  logic [31:0] reg_b = '0;
  logic [31:0] result;
  logic [2:0]  flags;
  logic        chk = 1'b0;
  logic        done = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  mips_alu #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .instruction (instruction),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .result      (result),
    .flags       (flags)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'b000000, 5'd0, 5'd0, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rtf, input logic [15:0] im);
    return {op, 5'd0, rtf, im};
  endfunction

  // Present one vector for one edge and queue what the outputs must show after it
  task automatic drive(input logic rst, input logic en, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [2:0] ef, input string nm);
    exp_t e;
    @(negedge clock);
    reset = rst; enable = en; instruction = ins; reg_a = a; reg_b = b; chk = 1'b1;
    e.r = er; e.f = ef; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: after each checked edge, pop the oldest expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      if (chk) begin
        #1;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: no expectation queued", "scoreboard");
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e.r) begin
            errors++;
            $display("FAIL %s result: got %h want %h", e.nm, result, e.r);
          end
          checks++;
          if (flags !== e.f) begin
            errors++;
            $display("FAIL %s flags: got %b want %b", e.nm, flags, e.f);
          end
        end
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, rtype(6'b100000, 0), 32'h1, 32'h1, 32'h0, 3'b000, "reset_init");
    drive(1'b1, 1'b0, rtype(6'b100000, 0), 32'h1, 32'h1, 32'h0, 3'b000, "hold_after_reset");
    drive(1'b1, 1'b1, rtype(6'b100000, 0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b110, "add_ovf");
    drive(1'b1, 1'b1, rtype(6'b100001, 0), 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b010, "addu");
    drive(1'b1, 1'b0, rtype(6'b100100, 0), 32'h0, 32'h0, 32'h80000000, 3'b010, "hold_nonzero");
    drive(1'b0, 1'b1, rtype(6'b100000, 0), 32'h7FFFFFFF, 32'h1, 32'h0, 3'b000, "reset_over_enable");
    drive(1'b1, 1'b0, rtype(6'b100000, 0), 32'h7FFFFFFF, 32'h1, 32'h0, 3'b000, "hold_zero");
    drive(1'b1, 1'b1, itype(6'b000100, 0, 16'h0), 32'd5, 32'd5, 32'h0, 3'b001, "beq");
    drive(1'b1, 1'b1, itype(6'b000101, 0, 16'h0), 32'd5, 32'd5, 32'h0, 3'b000, "bne");
    drive(1'b1, 1'b1, itype(6'b000001, 5'd1, 16'h0), 32'h0, 32'h0, 32'h0, 3'b001, "bgez");
    drive(1'b1, 1'b1, itype(6'b000001, 5'd0, 16'h0), 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 3'b011, "bltz");
    drive(1'b1, 1'b1, itype(6'b000001, 5'd2, 16'h0), 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 3'b010, "regimm_other");
    drive(1'b1, 1'b1, itype(6'b000110, 0, 16'h0), 32'h0, 32'h0, 32'h0, 3'b001, "blez_zero");
    drive(1'b1, 1'b1, itype(6'b000111, 0, 16'h0), 32'h0, 32'h0, 32'h0, 3'b000, "bgtz_zero");
    drive(1'b1, 1'b1, rtype(6'b000011, 5'd4), 32'h0, 32'hF0000000, 32'hFF000000, 3'b010, "sra");
    drive(1'b1, 1'b1, rtype(6'b000010, 5'd4), 32'h0, 32'hF0000000, 32'h0F000000, 3'b000, "srl");
    drive(1'b1, 1'b1, rtype(6'b000100, 5'd0), 32'd33, 32'h1, 32'h2, 3'b000, "sllv");
    drive(1'b1, 1'b1, rtype(6'b000000, 5'd0), 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3'b010, "sll_0");
    drive(1'b1, 1'b1, rtype(6'b000000, 5'd31), 32'h0, 32'h3, 32'h80000000, 3'b010, "sll_31");
    drive(1'b1, 1'b1, itype(6'b001101, 0, 16'h8001), 32'h0, 32'hFFFF8001, 32'h00008001, 3'b000, "ori");
    drive(1'b1, 1'b1, itype(6'b001100, 0, 16'hFF0F), 32'hFFFFFFFF, 32'h0, 32'h0000FF0F, 3'b000, "andi");
    drive(1'b1, 1'b1, itype(6'b001111, 0, 16'h1234), 32'h0, 32'h0, 32'h12340000, 3'b000, "lui");
    drive(1'b1, 1'b1, rtype(6'b101010, 0), 32'hFFFFFFFF, 32'h1, 32'h1, 3'b000, "slt");
    drive(1'b1, 1'b1, rtype(6'b101011, 0), 32'hFFFFFFFF, 32'h1, 32'h0, 3'b000, "sltu");
    drive(1'b1, 1'b1, itype(6'b100011, 0, 16'hFFFC), 32'h100, 32'hFFFFFFFC, 32'hFC, 3'b000, "lw");
    drive(1'b1, 1'b1, itype(6'b101011, 0, 16'h0001), 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b010, "sw_no_ovf");
    drive(1'b1, 1'b1, rtype(6'b100010, 0), 32'h80000000, 32'h1, 32'h7FFFFFFF, 3'b100, "sub_ovf");
    drive(1'b1, 1'b1, rtype(6'b100111, 0), 32'h0, 32'h0, 32'hFFFFFFFF, 3'b010, "nor");
    drive(1'b1, 1'b1, rtype(6'b001000, 0), 32'h12345678, 32'h1, 32'h0, 3'b000, "jr");
    drive(1'b1, 1'b1, itype(6'b000010, 0, 16'h1234), 32'h12345678, 32'h1, 32'h0, 3'b000, "j");
    drive(1'b1, 1'b1, itype(6'b001000, 0, 16'h0001), 32'h7FFFFFFF, 32'h1, 32'h80000000, 3'b110, "addi_ovf");
    @(negedge clock);
    chk = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending want 0", "drain", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL %s: bench did not complete", "timeout");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 32-bit MIPS-I integer ALU for the single-issue CPU datapath.
- Decodes the full 32-bit instruction word itself; opcode and funct select the operation.
- Operand A is always the rs value. Operand B is either the rt value or the sign-extended immediate, selected by the CPU's ALUSrc mux upstream.
- Produces a result word plus a 3-bit flag vector. The CPU uses flags[0] as the branch-taken condition.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- enable  in  1  capture enable; outputs hold when low
- instruction  in  32  full instruction word; [31:26] opcode, [20:16] rt field, [10:6] shamt, [5:0] funct
- reg_a  in  32  rs operand
- reg_b  in  32  rt value, or sign-extended imm16 for I-type
- result  out  32  registered ALU result / memory address
- flags  out  3  [0]=branch condition, [1]=negative (result[31]), [2]=signed overflow

Behaviour:
- reset low at a rising edge: result=0, flags=0. Reset has priority over enable.
- Otherwise, on a rising edge with enable=1, capture the combinational result and flags. Latency is 1 cycle. With enable=0, outputs hold.
- R-type (opcode 000000), by funct:
  - add 100000: a+b; overflow flag valid
  - addu 100001: a+b
  - sub 100010: a-b; overflow flag valid
  - subu 100011: a-b
  - and 100100, or 100101, xor 100110, nor 100111: bitwise
  - slt 101010: signed compare, result 1 or 0
  - sltu 101011: unsigned compare, result 1 or 0
  - sll 000000, srl 000010, sra 000011: shift b by shamt
  - sllv 000100, srlv 000110, srav 000111: shift b by a[4:0]
  - jr 001000: result 0, flags 0
- I-type:
  - addi 001000: a+b; overflow flag valid
  - addiu 001001: a+b
  - slti 001010: signed compare a<b
  - sltiu 001011: unsigned compare a<b (b is already sign-extended)
  - andi 001100, ori 001101, xori 001110: operand is {16'h0, instruction[15:0]}; zero-extend, ignore reg_b
  - lui 001111: {instruction[15:0], 16'h0}
- Loads 100000–100110 and stores 101000, 101001, 101010, 101011, 101110: result = a+b (byte address). Overflow never flagged.
- Branches compute a-b in result. flags[0] is set as follows:
  - beq 000100: a==b
  - bne 000101: a!=b
  - blez 000110: a signed <=0
  - bgtz 000111: a signed >0
  - regimm 000001: rt=00000 bltz (a<0); rt=00001 bgez (a>=0); other rt values give 0
- flags[0] is 0 for every non-branch opcode.
- j 000010, jal 000011, and any unlisted opcode or funct: result=0, flags=0.
- Overflow: set only for add/addi/sub when the operand signs make the two's-complement result wrong. No trap is raised; the wrapped result is still output. flags[2]=0 for all other operations.
- flags[1] = bit 31 of the captured result for every operation, including compares (always 0 there).
- Shift amount 0 passes b unchanged. Shift amount 31 behaves normally. sra replicates b[31].
- All arithmetic is modulo 2^32. Unsigned operations never set overflow.

Decomposition:
- Package mips_pkg: opcode localparams (OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ…OP_LUI, load/store ranges), funct localparams (F_SLL…F_SLTU, F_JR), and flag bit indices FLG_BR=0, FLG_NEG=1, FLG_OVF=2.
- One natural sub-module: alu_shifter, a combinational 32-bit barrel shifter with inputs value, amount[4:0] and mode {left, logical-right, arithmetic-right}.
- Decode, adder/subtractor, compares, logic ops and the output register stay in mips_alu.

Test Plan:
- reset=0 for one edge after arbitrary prior results → result=0, flags=3'b000. With enable=0 afterwards, outputs hold.
- add a=32'h7FFFFFFF, b=1 → result 32'h80000000, flags=3'b110. Same operands with addu → flags=3'b010.
- beq a=5, b=5 → flags[0]=1, result=0. bne with same operands → flags[0]=0, result=0. bgez (regimm rt=1) a=0 → flags[0]=1.
- sra shamt=4 on b=32'hF0000000 → 32'hFF000000. srl → 32'h0F000000. sllv a=33 (uses 1) on b=1 → 2.
- ori imm=16'h8001 with reg_b=32'hFFFF8001, a=0 → result 32'h00008001. lui imm=16'h1234 → 32'h12340000.
- slt a=-1, b=1 → 1. sltu a=-1, b=1 → 0. lw a=32'h100, b=32'hFFFFFFFC → result 32'hFC, flags[2]=0.
